// File: rtl/max7219_pkg.sv
// max7219_pkg -- shared constants for the MAX7219 daisy-chain serialiser.
//   FSM state encoding, Avalon register addresses, frame width and STAT bit positions.
package max7219_pkg;

  localparam int FRAME_W = 16;

  // FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STAT   = 2'd1;
  localparam logic [1:0] ADDR_CLKDIV = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  // STAT read layout {IE, OVF, FULL, EMPTY, BUSY}
  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_IE    = 4;

  // STAT write layout differs from the read layout
  localparam int STAT_WR_OVF_CLR = 2;
  localparam int STAT_WR_IE      = 3;

endpackage

// File: rtl/max7219_frame_fifo.sv
// max7219_frame_fifo -- synchronous show-ahead FIFO for serial frames.
//   clk, reset_n : clock, async active-low reset (pointers/count only)
//   push, din    : write strobe and data; accepted when not full or popping
//   pop, dout    : read strobe; dout always shows the head entry
//   full, empty, level : occupancy flags and count 0..DEPTH
module max7219_frame_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // a push while full is fine if the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/max7219_spi_ctrl.sv
// max7219_spi_ctrl -- Avalon-MM slave serialising 16-bit frames to a MAX7219 chain.
//   Groups of NUM_DEV frames are shifted MSB first, then LOAD rises to latch all devices.
//   Avalon: address, chipselect, write_n, writedata, readdata (combinational read)
//   Serial: max_din, max_clk (idle low), max_load (idle high, low while shifting)
//   irq   : present only when MAX7219_IRQ_EN is defined (irq = IE & EMPTY & ~BUSY)
module max7219_spi_ctrl
  import max7219_pkg::*;
#(
  parameter int NUM_DEV     = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_DEFAULT = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        max_din,
  output logic        max_clk,
  output logic        max_load
`ifdef MAX7219_IRQ_EN
  ,output logic       irq
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic               wr, wr_data, wr_stat;
  logic [15:0]        clkdiv;
  logic               ovf, ie, busy;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [FRAME_W-1:0] fifo_dout;
  logic [LW-1:0]      level;
  logic [2:0]         state;
  logic [15:0]        hcnt;
  logic [3:0]         bitcnt;
  logic [2:0]         devcnt;
  logic [FRAME_W-1:0] shreg;
  logic               half_done, group_ready, last_dev;
  logic               unused_wd;

  assign unused_wd = ^writedata[31:16];

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == ADDR_DATA);
  assign wr_stat = wr & (address == ADDR_STAT);
  assign busy    = (state != ST_IDLE);

  max7219_frame_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_data),
    .din     (writedata[FRAME_W-1:0]),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkdiv <= 16'(DIV_DEFAULT);
      ovf    <= 1'b0;
    end else begin
      if (wr & (address == ADDR_CLKDIV)) clkdiv <= writedata[15:0];
      if (wr_stat & writedata[STAT_WR_OVF_CLR]) ovf <= 1'b0;
      else if (wr_data & fifo_full & ~fifo_pop) ovf <= 1'b1;
    end
  end

`ifdef MAX7219_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ie <= 1'b0;
    else if (wr_stat) ie <= writedata[STAT_WR_IE];
  end
  assign irq = ie & fifo_empty & ~busy;
`else
  assign ie = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STAT: begin
        readdata[STAT_BUSY]  = busy;
        readdata[STAT_EMPTY] = fifo_empty;
        readdata[STAT_FULL]  = fifo_full;
        readdata[STAT_OVF]   = ovf;
        readdata[STAT_IE]    = ie;
      end
      ADDR_CLKDIV: readdata[15:0]   = clkdiv;
      ADDR_LEVEL:  readdata[LW-1:0] = level;
      default:     readdata = '0;
    endcase
  end

  // hcnt is reloaded from clkdiv at every half-period boundary, so a CLKDIV
  // write only changes the length of the next half-period.
  assign half_done   = (hcnt == '0);
  assign group_ready = (level >= LW'(NUM_DEV));
  assign last_dev    = (devcnt == 3'(NUM_DEV-1));
  assign fifo_pop    = ((state == ST_IDLE) & group_ready) |
                       ((state == ST_HIGH) & half_done & (bitcnt == 4'd15) & ~last_dev);

  // outputs are registered so max_clk/max_load never glitch on state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hcnt     <= '0;
      bitcnt   <= '0;
      devcnt   <= '0;
      shreg    <= '0;
      max_din  <= 1'b0;
      max_clk  <= 1'b0;
      max_load <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (group_ready) begin
          shreg    <= fifo_dout;
          max_din  <= fifo_dout[FRAME_W-1];
          max_load <= 1'b0;
          bitcnt   <= '0;
          devcnt   <= '0;
          hcnt     <= clkdiv;
          state    <= ST_SETUP;
        end
        ST_SETUP: if (half_done) begin
          max_clk <= 1'b1;
          hcnt    <= clkdiv;
          state   <= ST_HIGH;
        end else hcnt <= hcnt - 1'b1;
        ST_HIGH: if (half_done) begin
          max_clk <= 1'b0;
          hcnt    <= clkdiv;
          if (bitcnt != 4'd15) begin
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            max_din <= shreg[FRAME_W-2];
            bitcnt  <= bitcnt + 1'b1;
            state   <= ST_SETUP;
          end else if (!last_dev) begin
            shreg   <= fifo_dout;
            max_din <= fifo_dout[FRAME_W-1];
            bitcnt  <= '0;
            devcnt  <= devcnt + 1'b1;
            state   <= ST_SETUP;
          end else begin
            state   <= ST_LATCH;
          end
        end else hcnt <= hcnt - 1'b1;
        ST_LATCH: if (half_done) begin
          max_load <= 1'b1;
          hcnt     <= clkdiv;
          state    <= ST_GAP;
        end else hcnt <= hcnt - 1'b1;
        ST_GAP: if (half_done) state <= ST_IDLE;
                else hcnt <= hcnt - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
